// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shifter.
// Mode codes, FSM states and the mode legality check.
package shifter_pkg;

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ROL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  function automatic logic is_legal_mode(
    input logic [2:0] mode
  );
    return (mode <= MODE_ROL);
  endfunction

endpackage

// File: rtl/iter_shifter_if.sv
// Request/response bundle of the iterative shifter.
// Master issues start/operands, slave returns status and result.
interface iter_shifter_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             start;
  logic [2:0]       mode;
  logic [WIDTH-1:0] data_in;
  logic [SHW-1:0]   shamt;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out;

  modport master (
    output start,
    output mode,
    output data_in,
    output shamt,
    input  ready,
    input  busy,
    input  done,
    input  data_out
  );

  modport slave (
    input  start,
    input  mode,
    input  data_in,
    input  shamt,
    output ready,
    output busy,
    output done,
    output data_out
  );

endinterface

// File: rtl/shift1_stage.sv
// Combinational one-position shift/rotate step.
// Reserved modes pass the operand through unchanged.
module shift1_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] acc_sh
);

  always_comb begin
    acc_sh = acc;
    unique case (1'b1)
      (mode == MODE_SLL):
        acc_sh = {acc[WIDTH-2:0], 1'b0};
      (mode == MODE_SRL):
        acc_sh = {1'b0, acc[WIDTH-1:1]};
      (mode == MODE_SRA):
        acc_sh = {acc[WIDTH-1], acc[WIDTH-1:1]};
      (mode == MODE_ROR):
        acc_sh = {acc[0], acc[WIDTH-1:1]};
      (mode == MODE_ROL):
        acc_sh = {acc[WIDTH-2:0], acc[WIDTH-1]};
      default:
        acc_sh = acc;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter/rotator: one bit position per clock.
// IDLE -> SHIFT (shamt cycles) -> DONE (one-cycle result pulse).
module iter_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  iter_shifter_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] acc_sh;

  shift1_stage #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc    (acc_q),
    .mode   (mode_q),
    .acc_sh (acc_sh)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d   = bus.data_in;
          count_d = bus.shamt;
          mode_d  = bus.mode;
          if (bus.shamt != '0 &&
              is_legal_mode(bus.mode)) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
            dout_d  = bus.data_in;
          end
        end
      end
      ST_SHIFT: begin
        acc_d   = acc_sh;
        count_d = count_q - SHW'(1);
        // last step lands directly in the result register
        if (count_q == SHW'(1)) begin
          state_d = ST_DONE;
          dout_d  = acc_sh;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      mode_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.ready    = (state_q == ST_IDLE);
  assign bus.busy     = (state_q == ST_SHIFT) ||
                        (state_q == ST_DONE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.data_out = dout_q;

endmodule
